instr_encoder_loader: RTL



---
 rtl/mips_isa_pkg.sv | 57 +++++
 rtl/instr_encoder_loader_if.sv | 30 +++
 rtl/mips_field_encoder.sv | 46 ++++
 rtl/instr_encoder_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS-subset ISA constants: mnemonic select codes, opcodes, functs,
// loader FSM states and word-packing helpers used by the encoder and decoder.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    MN_SLL  = 5'd0,  MN_JR   = 5'd1,  MN_MFLO = 5'd2,  MN_MULT = 5'd3,
    MN_ADD  = 5'd4,  MN_OR   = 5'd5,  MN_SLT  = 5'd6,  MN_J    = 5'd7,
    MN_JAL  = 5'd8,  MN_BEQ  = 5'd9,  MN_BNE  = 5'd10, MN_URXF = 5'd11,
    MN_UTXF = 5'd12, MN_ADDI = 5'd13, MN_SLTI = 5'd14, MN_ANDI = 5'd15,
    MN_ORI  = 5'd16, MN_LUI  = 5'd17, MN_LW   = 5'd18, MN_SW   = 5'd19
  } mnemonic_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_URXF  = 6'h06;
  localparam logic [5:0] OP_UTXF  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [4:0] sh,
                                         logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] op, logic [4:0] rs,
                                         logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(logic [5:0] op, logic [25:0] tgt);
    return {op, tgt};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request/write-port bundle between an instruction source and the loader.
interface instr_encoder_loader_if #(parameter int ADDR_WIDTH = 8);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            mnemonic;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [15:0]           imm;
  logic [25:0]           target;
  logic                  last;
  logic                  restart;
  logic                  im_we;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [31:0]           im_wdata;
  logic                  done;
  logic                  err_illegal;
  logic                  err_full;

  modport master (
    output in_valid, mnemonic, rs, rt, rd, shamt, imm, target, last, restart,
    input  in_ready, im_we, im_addr, im_wdata, done, err_illegal, err_full
  );

  modport slave (
    input  in_valid, mnemonic, rs, rt, rd, shamt, imm, target, last, restart,
    output in_ready, im_we, im_addr, im_wdata, done, err_illegal, err_full
  );
endinterface

// File: rtl/mips_field_encoder.sv
// Combinational packer: mnemonic + operand fields -> 32-bit MIPS word.
// Fields a format does not use are forced to zero; codes 20-31 flag illegal.
module mips_field_encoder
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnemonic_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (mnemonic_i)
      MN_SLL:  word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
      MN_JR:   word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      MN_MFLO: word_o = r_word(5'd0, 5'd0, rd_i, 5'd0, FN_MFLO);
      MN_MULT: word_o = r_word(rs_i, rt_i, 5'd0, 5'd0, FN_MULT);
      MN_ADD:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
      MN_OR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
      MN_SLT:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
      MN_J:    word_o = j_word(OP_J, target_i);
      MN_JAL:  word_o = j_word(OP_JAL, target_i);
      MN_BEQ:  word_o = i_word(OP_BEQ, rs_i, rt_i, imm_i);
      MN_BNE:  word_o = i_word(OP_BNE, rs_i, rt_i, imm_i);
      MN_URXF: word_o = i_word(OP_URXF, rs_i, rt_i, imm_i);
      MN_UTXF: word_o = i_word(OP_UTXF, rs_i, rt_i, imm_i);
      MN_ADDI: word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
      MN_SLTI: word_o = i_word(OP_SLTI, rs_i, rt_i, imm_i);
      MN_ANDI: word_o = i_word(OP_ANDI, rs_i, rt_i, imm_i);
      MN_ORI:  word_o = i_word(OP_ORI, rs_i, rt_i, imm_i);
      // lui has no source register
      MN_LUI:  word_o = i_word(OP_LUI, 5'd0, rt_i, imm_i);
      MN_LW:   word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
      MN_SW:   word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts instruction requests, encodes them and writes them sequentially into
// instruction memory; two cycles per instruction, stops at last or when full.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_encoder_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           word_q;
  logic                  last_q;
  logic                  we_q, rdy_q, done_q;
  logic                  err_ill_q, err_full_q;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;

  mips_field_encoder u_enc (
    .mnemonic_i (bus.mnemonic),
    .rs_i       (bus.rs),
    .rt_i       (bus.rt),
    .rd_i       (bus.rd),
    .shamt_i    (bus.shamt),
    .imm_i      (bus.imm),
    .target_i   (bus.target),
    .word_o     (enc_word),
    .illegal_o  (enc_illegal)
  );

  assign accept = bus.in_valid & rdy_q;
  // Saturate at the top word so a full memory never wraps onto address 0.
  assign addr_d = (addr_q == ADDR_MAX) ? addr_q : addr_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
      err_ill_q  <= 1'b0;
      err_full_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (enc_illegal) begin
              err_ill_q <= 1'b1;
              if (bus.last) begin
                state_q <= ST_DONE;
                rdy_q   <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              word_q  <= enc_word;
              last_q  <= bus.last;
              state_q <= ST_WRITE;
              rdy_q   <= 1'b0;
              we_q    <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          we_q   <= 1'b0;
          addr_q <= addr_d;
          if (last_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (addr_q == ADDR_MAX) begin
            err_full_q <= 1'b1;
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.restart) begin
            addr_q     <= '0;
            err_ill_q  <= 1'b0;
            err_full_q <= 1'b0;
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = rdy_q;
  assign bus.im_we       = we_q;
  assign bus.im_addr     = addr_q;
  assign bus.im_wdata    = word_q;
  assign bus.done        = done_q;
  assign bus.err_illegal = err_ill_q;
  assign bus.err_full    = err_full_q;

endmodule
